// File: rtl/uart_pkg.sv
// uart_pkg: serial-frame state encodings and defaults shared by the UART transmitter and receiver.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 1085;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with wrap-around pointers and occupancy count; push while full is dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serialiser; txd is registered from the current state, so it lags the FSM by one clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);
  localparam int CW = cnt_width(CLKS_PER_BIT);
  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n, dout;
  logic          txd_n, pop, full, empty, last;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_valid),
    .pop  (pop),
    .din  (tx_data),
    .dout (dout),
    .full (full),
    .empty(empty)
  );
  assign tx_ready = !full;
  assign tx_busy  = (state != IDLE) || !empty;
  assign last     = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    txd_n   = (state == START) ? 1'b0 : (state == DATA) ? shift[idx] : 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = dout;
          state_n = START;
        end
      end
      START:
        if (last) begin
          state_n = DATA;
          idx_n   = '0;
        end
      DATA:
        if (last) begin
          state_n = (idx == 3'd7) ? STOP : DATA;
          idx_n   = (idx == 3'd7) ? idx : idx + 3'd1;
        end
      STOP:
        if (last) begin
          pop     = !empty;
          shift_n = empty ? shift : dout;
          state_n = empty ? IDLE : START;
        end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        txd_n   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      txd   <= txd_n;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1085, clk cycles per serial bit (115200 baud at 125 MHz).
REQ-002 Parameter: FIFO_DEPTH, default 4, byte entries in the transmit buffer; power of two, minimum 2.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Port: tx_data  input  8  byte to transmit.
REQ-006 Port: tx_valid  input  1  tx_data valid this cycle.
REQ-007 Port: tx_ready  output  1  buffer can accept a byte this cycle.
REQ-008 Port: txd  output  1  serial line, 8N1, idle high, registered.
REQ-009 Port: tx_busy  output  1  frame in progress or buffer non-empty.

Function
REQ-010 The byte SHALL be written when tx_valid and tx_ready are both high at a rising edge; tx_valid with tx_ready low SHALL be ignored with no side effect.
REQ-011 tx_ready SHALL equal NOT full; a push while full SHALL be rejected even if a pop occurs in the same cycle.
REQ-012 Buffer SHALL be FIFO-ordered, with wrap-around read and write pointers and an occupancy count 0..FIFO_DEPTH.
REQ-013 The serialiser SHALL implement four states: IDLE, START, DATA, STOP.
REQ-014 IDLE: txd=1; if the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
REQ-015 START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-016 DATA: txd=shift[index], LSB first, each bit held exactly CLKS_PER_BIT cycles; after bit 7, go to STOP.
REQ-017 STOP: txd=1 for exactly CLKS_PER_BIT cycles; at the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-018 Latency: a byte pushed into an empty FIFO while IDLE at edge N SHALL drive txd low from edge N+2.
REQ-019 A frame SHALL be exactly 10*CLKS_PER_BIT cycles long; a new push never disturbs a frame in progress.
REQ-020 tx_busy SHALL be high whenever the state is not IDLE or the FIFO is non-empty.
REQ-021 The bit-period counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, and clear on every state change.
REQ-022 An illegal state encoding SHALL return to IDLE with txd=1 on the next edge.

Reset
REQ-023 While rst=0: state=IDLE, txd=1, FIFO empty (pointers and count 0), bit counter 0, bit index 0, tx_busy=0, tx_ready=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously) and discard all buffered bytes.
REQ-025 After rst deasserts, the first accepted push SHALL follow REQ-018 timing.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and CLKS_PER_BIT default 1085, shared with the receiver.
REQ-027 The buffer SHALL be a sub-module, uart_tx_fifo (parameterised depth, push/pop/full/empty/dout); the serialiser FSM SHALL reside in uart_tx.

Verification
REQ-028 Single byte: push 0x72 when idle -> txd low at edge N+2 for 1085 cycles, then 0,1,0,0,1,1,1,0 at 1085 cycles each, high stop bit; tx_busy falls after the stop bit.
REQ-029 Back-to-back: push 0x67 then 0x62 on consecutive cycles -> two frames with the second start bit immediately after the first stop bit; 20*1085 cycles total.
REQ-030 Full: push 6 bytes on consecutive cycles from idle -> byte 1 popped, bytes 2-5 held, tx_ready=0 at the 6th push, which is dropped; bytes 1-5 transmitted in order.
REQ-031 Reset mid-frame: assert rst during DATA bit 3 of 0xA5 with 2 bytes queued -> txd=1 at once, tx_busy=0, tx_ready=1; no further frame after release until a new push.
REQ-032 Loopback: txd to the team's UART receiver, send 0x72, 0x67, 0x62 -> ld6r, ld6g, then ld6b light in turn.
REQ-033 Random: 1000 random bytes with random tx_valid gaps -> received byte stream matches the accepted pushes exactly; no push is accepted while full.
